// File: rtl/poly_raster_ctrl_pkg.sv
// Shared types for the polygon wireframe raster controller: screen defaults,
// point/color typedefs, the FSM state encoding and the edge-count rule.
package poly_raster_ctrl_pkg;

   localparam int WIDTH_DEF       = 640;
   localparam int HEIGHT_DEF      = 480;
   localparam int COORD_W_DEF     = 16;
   localparam int MAX_VERTS_DEF   = 4;
   localparam int CLEAR_LANES_DEF = 1;

   typedef struct packed {
      logic signed [COORD_W_DEF-1:0] y;
      logic signed [COORD_W_DEF-1:0] x;
   } point2d_t;

   typedef logic [23:0] color_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_CLEAR,
      ST_SETUP,
      ST_DRAW,
      ST_DONE
   } poly_raster_state_t;

   // A lone point draws nothing, two vertices form an open segment, more close the loop.
   function automatic int edge_count(input int nverts);
      if (nverts <= 1) return 0;
      if (nverts == 2) return 1;
      return nverts;
   endfunction

endpackage

// File: rtl/poly_raster_ctrl_if.sv
// Primitive, line-engine and clear-strobe signals of the polygon raster controller.
interface poly_raster_ctrl_if #(
   parameter int COORD_W   = 16,
   parameter int MAX_VERTS = 4
);
   localparam int NV_W = $clog2(MAX_VERTS + 1);

   logic                            prim_valid;
   logic                            prim_ready;
   logic [NV_W-1:0]                 prim_nverts;
   logic [MAX_VERTS*2*COORD_W-1:0]  prim_verts;
   logic                            prim_clear;
   logic [23:0]                     prim_color;
   logic                            cf_ready;
   logic                            line_start;
   logic [2*COORD_W-1:0]            line_p;
   logic [2*COORD_W-1:0]            line_q;
   logic [23:0]                     line_color;
   logic                            line_done;
   logic                            clear;
   logic [COORD_W-1:0]              clear_x;
   logic [COORD_W-1:0]              clear_y;
   logic                            done;
   logic                            busy;

   modport slave (
      input  prim_valid, prim_nverts, prim_verts, prim_clear, prim_color, cf_ready, line_done,
      output prim_ready, line_start, line_p, line_q, line_color, clear, clear_x, clear_y, done, busy
   );

   modport master (
      output prim_valid, prim_nverts, prim_verts, prim_clear, prim_color, cf_ready, line_done,
      input  prim_ready, line_start, line_p, line_q, line_color, clear, clear_x, clear_y, done, busy
   );

endinterface

// File: rtl/poly_edge_sel.sv
// Edge endpoint mux: vertex e and vertex (e+1) mod nverts from the packed vertex array.
module poly_edge_sel #(
   parameter int  COORD_W   = 16,
   parameter int  MAX_VERTS = 4,
   localparam int NV_W      = $clog2(MAX_VERTS + 1),
   localparam int PW        = 2 * COORD_W
) (
   input  logic [MAX_VERTS*PW-1:0] verts,
   input  logic [NV_W-1:0]         e_idx,
   input  logic [NV_W-1:0]         nverts,
   output logic [PW-1:0]           p,
   output logic [PW-1:0]           q
);

   logic [NV_W-1:0] q_idx;

   always_comb begin
      q_idx = e_idx + NV_W'(1);
      if (q_idx >= nverts) q_idx = '0;
      p = '0;
      q = '0;
      for (int i = 0; i < MAX_VERTS; i++) begin
         if (e_idx == NV_W'(i)) p = verts[i*PW +: PW];
         if (q_idx == NV_W'(i)) q = verts[i*PW +: PW];
      end
   end

endmodule

// File: rtl/poly_raster_ctrl.sv
// Polygon wireframe raster controller: optional buffer clear, then one line-engine job per edge.
// Define POLY_RASTER_DEGEN_CULL_EN to skip zero-length edges without starting the line engine.
module poly_raster_ctrl
   import poly_raster_ctrl_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int HEIGHT      = HEIGHT_DEF,
   parameter int COORD_W     = COORD_W_DEF,
   parameter int MAX_VERTS   = MAX_VERTS_DEF,
   parameter int CLEAR_LANES = CLEAR_LANES_DEF
) (
   input logic               clk,
   input logic               n_rst,
   poly_raster_ctrl_if.slave bus
);

   // state      | meaning
   // IDLE       | waiting for a polygon, prim_ready follows cf_ready
   // CAPTURE    | polygon latched, edge count derived
   // CLEAR      | scanning the buffer, CLEAR_LANES pixels per cycle
   // SETUP      | line_start pulse for edge e
   // DRAW       | endpoints held until line_done
   // DONE       | one-cycle done pulse

   localparam int                NV_W   = $clog2(MAX_VERTS + 1);
   localparam int                PW     = 2 * COORD_W;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - CLEAR_LANES);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);
   localparam logic [COORD_W-1:0] X_STEP = COORD_W'(CLEAR_LANES);
   localparam logic [NV_W-1:0]    NV_MAX = NV_W'(MAX_VERTS);

   poly_raster_state_t      state;
   logic [MAX_VERTS*PW-1:0] verts_q;
   logic [NV_W-1:0]         nverts_q;
   logic [NV_W-1:0]         edge_cnt;
   logic [NV_W-1:0]         e_idx;
   logic [NV_W-1:0]         e_nxt;
   logic [NV_W-1:0]         e_sel;
   logic                    clear_req;
   logic                    ready_en;
   logic                    edge_ok;
   logic [PW-1:0]           sel_p;
   logic [PW-1:0]           sel_q;

   assign bus.prim_ready = ready_en & bus.cf_ready;
   assign e_nxt          = e_idx + NV_W'(1);
   // Endpoints are registered on entry to SETUP, so look at the edge about to be issued.
   assign e_sel          = (state == ST_SETUP || state == ST_DRAW) ? e_nxt : '0;

`ifdef POLY_RASTER_DEGEN_CULL_EN
   assign edge_ok = (sel_p != sel_q);
`else
   assign edge_ok = 1'b1;
`endif

   poly_edge_sel #(
      .COORD_W   (COORD_W),
      .MAX_VERTS (MAX_VERTS)
   ) u_edge_sel (
      .verts  (verts_q),
      .e_idx  (e_sel),
      .nverts (nverts_q),
      .p      (sel_p),
      .q      (sel_q)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= ST_IDLE;
         verts_q        <= '0;
         nverts_q       <= '0;
         edge_cnt       <= '0;
         e_idx          <= '0;
         clear_req      <= 1'b0;
         ready_en       <= 1'b0;
         bus.line_start <= 1'b0;
         bus.line_p     <= '0;
         bus.line_q     <= '0;
         bus.line_color <= '0;
         bus.clear      <= 1'b0;
         bus.clear_x    <= '0;
         bus.clear_y    <= '0;
         bus.done       <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         bus.line_start <= 1'b0;
         bus.done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               ready_en <= 1'b1;
               if (bus.prim_valid && bus.prim_ready) begin
                  verts_q        <= bus.prim_verts;
                  nverts_q       <= (bus.prim_nverts > NV_MAX) ? NV_MAX : bus.prim_nverts;
                  bus.line_color <= color_t'(bus.prim_color);
                  clear_req      <= bus.prim_clear;
                  ready_en       <= 1'b0;
                  bus.busy       <= 1'b1;
                  state          <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               e_idx    <= '0;
               edge_cnt <= NV_W'(edge_count(int'(nverts_q)));
               if (clear_req) begin
                  bus.clear   <= 1'b1;
                  bus.clear_x <= '0;
                  bus.clear_y <= '0;
                  state       <= ST_CLEAR;
               end else if (nverts_q <= NV_W'(1)) begin
                  bus.done <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  bus.line_start <= edge_ok;
                  bus.line_p     <= sel_p;
                  bus.line_q     <= sel_q;
                  state          <= ST_SETUP;
               end
            end
            ST_CLEAR: begin
               if (bus.clear_x == X_LAST) begin
                  bus.clear_x <= '0;
                  if (bus.clear_y == Y_LAST) begin
                     bus.clear   <= 1'b0;
                     bus.clear_y <= '0;
                     if (edge_cnt == '0) begin
                        bus.done <= 1'b1;
                        state    <= ST_DONE;
                     end else begin
                        bus.line_start <= edge_ok;
                        bus.line_p     <= sel_p;
                        bus.line_q     <= sel_q;
                        state          <= ST_SETUP;
                     end
                  end else begin
                     bus.clear_y <= bus.clear_y + COORD_W'(1);
                  end
               end else begin
                  bus.clear_x <= bus.clear_x + X_STEP;
               end
            end
            ST_SETUP: begin
`ifdef POLY_RASTER_DEGEN_CULL_EN
               if (!bus.line_start) begin
                  e_idx <= e_nxt;
                  if (e_nxt == edge_cnt) begin
                     bus.done   <= 1'b1;
                     bus.line_p <= '0;
                     bus.line_q <= '0;
                     state      <= ST_DONE;
                  end else begin
                     bus.line_start <= edge_ok;
                     bus.line_p     <= sel_p;
                     bus.line_q     <= sel_q;
                     state          <= ST_SETUP;
                  end
               end else begin
                  state <= ST_DRAW;
               end
`else
               state <= ST_DRAW;
`endif
            end
            ST_DRAW: begin
               if (bus.line_done) begin
                  e_idx <= e_nxt;
                  if (e_nxt == edge_cnt) begin
                     bus.done   <= 1'b1;
                     bus.line_p <= '0;
                     bus.line_q <= '0;
                     state      <= ST_DONE;
                  end else begin
                     bus.line_start <= edge_ok;
                     bus.line_p     <= sel_p;
                     bus.line_q     <= sel_q;
                     state          <= ST_SETUP;
                  end
               end
            end
            ST_DONE: begin
               bus.busy <= 1'b0;
               ready_en <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_raster_ctrl.sv
// Directed bench for poly_raster_ctrl on an 8x4 screen cleared four pixels per cycle.
module tb_poly_raster_ctrl;

   localparam int CW = 16;
   localparam int MV = 4;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   poly_raster_ctrl_if #(.COORD_W(CW), .MAX_VERTS(MV)) bus ();

   poly_raster_ctrl #(
      .WIDTH       (8),
      .HEIGHT      (4),
      .COORD_W     (CW),
      .MAX_VERTS   (MV),
      .CLEAR_LANES (4)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   int          done_at;
   int          done_cnt;
   int          first_clr;
   bit          stable_bad;
   int          start_cyc[$];
   logic [31:0] sp[$];
   logic [31:0] sq[$];
   logic [15:0] cx[$];
   logic [15:0] cy[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pt(input int x, input int y);
      return {16'(y), 16'(x)};
   endfunction

   function automatic logic [127:0] vset(input logic [31:0] v0, input logic [31:0] v1,
                                         input logic [31:0] v2, input logic [31:0] v3);
      return {v3, v2, v1, v0};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},       bus.busy, 0);
      chk({tag, "_ready"},      bus.prim_ready, 0);
      chk({tag, "_line_start"}, bus.line_start, 0);
      chk({tag, "_line_p"},     bus.line_p, 0);
      chk({tag, "_line_q"},     bus.line_q, 0);
      chk({tag, "_line_color"}, bus.line_color, 0);
      chk({tag, "_clear"},      bus.clear, 0);
      chk({tag, "_clear_xy"},   {bus.clear_y, bus.clear_x}, 0);
      chk({tag, "_done"},       bus.done, 0);
   endtask

   // Offers one polygon, acts as line engine (line_done 3 cycles after each start) and logs
   // events by cycle number, the handshake cycle being 0. Stops 2 cycles after done or at stop_at.
   task automatic run_poly(input logic [2:0] nv, input logic [127:0] vv, input logic clr,
                           input logic [23:0] col, input int stop_at);
      int n = 0;
      int s = 0;
      bit pend = 0;
      start_cyc.delete(); sp.delete(); sq.delete(); cx.delete(); cy.delete();
      done_at = -1; done_cnt = 0; first_clr = -1; stable_bad = 0;
      bus.prim_valid  = 1'b1;
      bus.prim_nverts = nv;
      bus.prim_verts  = vv;
      bus.prim_clear  = clr;
      bus.prim_color  = col;
      #1;
      chk("hs_ready", bus.prim_ready, 1);
      while (n < 300) begin
         @(posedge clk); #1;
         n++;
         bus.prim_valid = 1'b0;
         bus.line_done  = 1'b0;
         if (bus.clear) begin
            cx.push_back(bus.clear_x);
            cy.push_back(bus.clear_y);
            if (first_clr < 0) first_clr = n;
         end
         if (bus.line_start) begin
            start_cyc.push_back(n);
            sp.push_back(bus.line_p);
            sq.push_back(bus.line_q);
            pend = 1;
            s = n;
         end else if (pend && (bus.line_p !== sp[$] || bus.line_q !== sq[$])) begin
            stable_bad = 1;
         end
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
         end
         if (pend && n == s + 3) begin
            bus.line_done = 1'b1;
            pend = 0;
         end
         if ((done_at >= 0 && n >= done_at + 2) || n == stop_at) break;
      end
      bus.line_done = 1'b0;
   endtask

   task automatic post_checks(input string tag, input int exp_done, input int exp_starts,
                              input int exp_first, input int exp_clr, input logic [23:0] col);
      chk({tag, "_done_at"},    done_at, exp_done);
      chk({tag, "_done_cnt"},   done_cnt, 1);
      chk({tag, "_starts"},     start_cyc.size(), exp_starts);
      chk({tag, "_clear_cnt"},  cx.size(), exp_clr);
      chk({tag, "_stable"},     stable_bad, 0);
      chk({tag, "_idle_busy"},  bus.busy, 0);
      chk({tag, "_idle_p"},     {bus.line_q, bus.line_p}, 0);
      chk({tag, "_color_hold"}, bus.line_color, col);
      chk({tag, "_ready_back"}, bus.prim_ready, 1);
      for (int i = 0; i < start_cyc.size(); i++)
         chk({tag, "_start_cyc"}, start_cyc[i], exp_first + 4 * i);
   endtask

   initial begin
      bus.prim_valid  = 1'b0;
      bus.prim_nverts = '0;
      bus.prim_verts  = '0;
      bus.prim_clear  = 1'b0;
      bus.prim_color  = '0;
      bus.cf_ready    = 1'b1;
      bus.line_done   = 1'b0;

      #3;
      chk_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;

      // Closed triangle without clear
      run_poly(3'd3, vset(pt(0,0), pt(5,0), pt(0,5), '0), 1'b0, 24'h112233, 0);
      post_checks("tri", 14, 3, 2, 0, 24'h112233);
      chk("tri_e0", {sq[0], sp[0]}, {pt(5,0), pt(0,0)});
      chk("tri_e1", {sq[1], sp[1]}, {pt(0,5), pt(5,0)});
      chk("tri_e2", {sq[2], sp[2]}, {pt(0,0), pt(0,5)});

      // Triangle with clear: 8 clear cycles scanning (0,0),(4,0),(0,1)...(4,3)
      run_poly(3'd3, vset(pt(0,0), pt(5,0), pt(0,5), '0), 1'b1, 24'hABCDEF, 0);
      post_checks("clr_tri", 22, 3, 10, 8, 24'hABCDEF);
      chk("clr_first", first_clr, 2);
      for (int i = 0; i < 8; i++)
         chk("clr_xy", {cy[i], cx[i]}, {16'(i / 2), 16'((i % 2) * 4)});

      // Open segment
      run_poly(3'd2, vset(pt(1,1), pt(6,3), '0, '0), 1'b0, 24'h00FF00, 0);
      post_checks("seg", 6, 1, 2, 0, 24'h00FF00);
      chk("seg_e0", {sq[0], sp[0]}, {pt(6,3), pt(1,1)});

      // Single vertex with clear, then empty polygon
      run_poly(3'd1, vset(pt(3,3), '0, '0, '0), 1'b1, 24'h010203, 0);
      post_checks("nv1", 10, 0, 0, 8, 24'h010203);
      run_poly(3'd0, '0, 1'b0, 24'h040506, 0);
      post_checks("nv0", 2, 0, 0, 0, 24'h040506);

      // Frame buffer not ready: no capture
      bus.cf_ready    = 1'b0;
      bus.prim_valid  = 1'b1;
      bus.prim_nverts = 3'd4;
      bus.prim_verts  = vset(pt(0,0), pt(4,0), pt(4,4), pt(0,4));
      #1;
      chk("cf_low_ready", bus.prim_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("cf_low_busy", bus.busy, 0);
      end
      bus.cf_ready = 1'b1;

      // Quad aborted by reset during the second edge's DRAW
      run_poly(3'd4, vset(pt(0,0), pt(4,0), pt(4,4), pt(0,4)), 1'b0, 24'h778899, 8);
      chk("abort_starts", start_cyc.size(), 2);
      n_rst = 1'b0;
      #1;
      chk_all_zero("abort");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", bus.done, 0);
      end
      n_rst = 1'b1;
      @(posedge clk); #1;

      run_poly(3'd4, vset(pt(0,0), pt(4,0), pt(4,4), pt(0,4)), 1'b0, 24'h778899, 0);
      post_checks("quad", 18, 4, 2, 0, 24'h778899);
      chk("quad_e2", {sq[2], sp[2]}, {pt(0,4), pt(4,4)});
      chk("quad_e3", {sq[3], sp[3]}, {pt(0,0), pt(0,4)});

      // Vertex count above MAX_VERTS is clamped to 4
      run_poly(3'd5, vset(pt(0,0), pt(4,0), pt(4,4), pt(0,4)), 1'b0, 24'h0A0B0C, 0);
      post_checks("clamp", 18, 4, 2, 0, 24'h0A0B0C);
      chk("clamp_e3", {sq[3], sp[3]}, {pt(0,0), pt(0,4)});

      // Zero-length first edge
      run_poly(3'd3, vset(pt(2,2), pt(2,2), pt(7,2), '0), 1'b0, 24'h123456, 0);
`ifdef POLY_RASTER_DEGEN_CULL_EN
      post_checks("degen", 11, 2, 3, 0, 24'h123456);
      chk("degen_e1", {sq[0], sp[0]}, {pt(7,2), pt(2,2)});
      chk("degen_e2", {sq[1], sp[1]}, {pt(2,2), pt(7,2)});
`else
      post_checks("degen", 14, 3, 2, 0, 24'h123456);
      chk("degen_e0", {sq[0], sp[0]}, {pt(2,2), pt(2,2)});
      chk("degen_e1", {sq[1], sp[1]}, {pt(7,2), pt(2,2)});
      chk("degen_e2", {sq[2], sp[2]}, {pt(2,2), pt(7,2)});
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/poly_raster_ctrl.md
Name: poly_raster_ctrl

Overview:
- Parametrised successor to the triangle wireframe rasterizer controller.
- Accepts one pre-projected polygon of 2..MAX_VERTS screen-space vertices through a valid/ready handshake.
- Optionally clears the wireframe buffer CLEAR_LANES pixels per cycle, then sequences each polygon edge to the line-drawing (Bresenham) engine.
- Sits between the primitive FIFO/projection stage and the line engine / frame buffer.

Parameters:
- WIDTH, 640, screen width in pixels; must be a multiple of CLEAR_LANES.
- HEIGHT, 480, screen height in pixels.
- COORD_W, 16, signed coordinate width per axis.
- MAX_VERTS, 4, maximum vertices per polygon (≥3).
- CLEAR_LANES, 1, pixels cleared per cycle (power of two).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- prim_valid  in  1  polygon available
- prim_ready  out  1  controller accepts polygon this cycle
- prim_nverts  in  $clog2(MAX_VERTS+1)  vertex count
- prim_verts  in  MAX_VERTS*2*COORD_W  packed {y,x} per vertex; vertex 0 in LSBs
- prim_clear  in  1  clear buffer before drawing this polygon
- prim_color  in  24  polygon color
- cf_ready  in  1  frame buffer ready for a new primitive
- line_start  out  1  one-cycle pulse starting an edge
- line_p  out  2*COORD_W  edge start {y,x}
- line_q  out  2*COORD_W  edge end {y,x}
- line_color  out  24  captured color
- line_done  in  1  line engine finished current edge
- clear  out  1  clear-write strobe
- clear_x  out  COORD_W  first pixel x of the current clear group
- clear_y  out  COORD_W  clear row
- done  out  1  one-cycle pulse when the polygon is complete
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, n_rst=0): state IDLE. All outputs 0 except prim_ready=0. Captured registers and counters cleared. Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, CAPTURE, CLEAR, SETUP, DRAW, DONE.
- IDLE: prim_ready = cf_ready. A transfer occurs when prim_valid & prim_ready → CAPTURE.
- CAPTURE: register verts, nverts, color and clear flag.
  - prim_clear=1 → CLEAR, with clear_x=0 and clear_y=0.
  - Otherwise → SETUP.
  - In both cases, edge index e=0 and edge count E are computed:
    - nverts ≤ 1 → E=0; go directly to DONE (skip CLEAR only if prim_clear=0).
    - nverts = 2 → E=1; open segment.
    - nverts ≥ 3 → E=nverts; closed polygon.
    - nverts > MAX_VERTS → clamped to MAX_VERTS.
- CLEAR: clear=1 every cycle.
  - clear_x advances by CLEAR_LANES. On clear_x = WIDTH-CLEAR_LANES it wraps to 0 and clear_y increments.
  - After the cycle with clear_x = WIDTH-CLEAR_LANES and clear_y = HEIGHT-1, the next state is SETUP, or DONE if E=0.
  - Exactly WIDTH*HEIGHT/CLEAR_LANES clear cycles, with no extra row.
- SETUP: line_start=1 for one cycle. line_p = vert[e]; line_q = vert[(e+1) mod nverts]. → DRAW.
- DRAW: line_p and line_q are held stable. line_done is sampled only in DRAW; in SETUP it is ignored.
  - On line_done, e increments.
  - If the new e = E → DONE; otherwise → SETUP.
- DONE: done=1 for one cycle → IDLE. prim_ready may assert on the following cycle.
- line_p and line_q read 0 outside SETUP/DRAW. line_color holds the captured color until the next capture.
- Coordinates pass through unmodified. Clipping is the line engine's responsibility.

Optional Feature:
- Macro: POLY_RASTER_DEGEN_CULL_EN.
- Defined: in SETUP, an edge with line_p == line_q issues no line_start. The edge advances as if complete (1 cycle) and the controller never enters DRAW for it.
- Undefined: zero-length edges are issued normally and wait for line_done.

Decomposition:
- Shared defines package: WIDTH/HEIGHT defaults, Point2D (signed COORD_W x,y), Color typedef, and the poly_raster_state_t enum.
- One natural sub-module, poly_edge_sel: combinational vertex mux that, given the vertex array, e and nverts, produces the edge endpoints with the mod-nverts wrap.
- The clear-scan counter stays inline.

Test Plan:
1. Triangle, prim_clear=0, verts (0,0),(5,0),(0,5); line_done 3 cycles after each start → three starts with edges (0,0)->(5,0), (5,0)->(0,5), (0,5)->(0,0); one done; 3 SETUP + 3×3 DRAW cycles.
2. WIDTH=8, HEIGHT=4, CLEAR_LANES=4, prim_clear=1, triangle → clear high exactly 8 cycles, (x,y) sequence (0,0),(4,0),(0,1)…(4,3); then first line_start.
3. nverts=2, (1,1)->(6,3) → single line_start, no closing edge; done follows.
4. nverts=1 with prim_clear=1 → full clear, zero line_start, done. nverts=0 with prim_clear=0 → done 2 cycles after the handshake.
5. Quad with cf_ready low → prim_ready=0 and no capture. Raise cf_ready, then assert n_rst=0 in the second DRAW → all outputs 0 and no done. After release, resubmit → 4 edges complete.
6. POLY_RASTER_DEGEN_CULL_EN defined, verts (2,2),(2,2),(7,2) → line_start only for (2,2)->(7,2) and (7,2)->(2,2); without the macro, 3 starts.
